sram_arb_2ch: RTL and testbench
===============================

SRAM_ARB_2CH -- requirements
Module: sram_arb_2ch

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width (depth 2**ADDR_W words) SHALL be supported.
REQ-002 Parameter DATA_W, default 8, memory word width SHALL be supported.
REQ-003 clk  input  1  single clock; all state SHALL change on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1  access request, channel 0 / 1.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr0 / addr1  input  ADDR_W  word address.
REQ-008 wdata0 / wdata1  input  DATA_W  write data.
REQ-009 gnt0 / gnt1  output  1  one-cycle pulse: command accepted.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse: read data valid.
REQ-011 rdata0 / rdata1  output  DATA_W  read data, held until the next read on that channel.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, RESP; no other states.
REQ-014 IDLE: if any req is high at a clock edge, latch the winner's we/addr/wdata and go to ACCESS; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: a single request wins; on both requesting, the channel not granted last wins; after reset ch0 wins first.
REQ-016 gnt of the winner SHALL be 1 for exactly the ACCESS cycle; both gnt never high together.
REQ-017 ACCESS: write SHALL commit mem[addr]=wdata at the closing edge; read SHALL register mem[addr] into the winner's rdata at the closing edge; then go to RESP.
REQ-018 RESP: winner's rvalid SHALL be 1 for one cycle on reads only (0 for writes); then go to IDLE.
REQ-019 Latency: req sampled at edge N -> gnt in cycle N+1 -> rvalid/rdata in cycle N+2; throughput one access per 3 cycles.
REQ-020 req/we/addr/wdata SHALL be ignored in ACCESS and RESP; a req still high on return to IDLE SHALL count as a new request.
REQ-021 Requesters SHALL hold req and fields stable until gnt; dropping req before gnt withdraws the request with no memory effect.
REQ-022 Read after write to same address by either channel SHALL return the new data (accesses fully serialized).
REQ-023 Address SHALL be used modulo 2**ADDR_W; no out-of-range error exists.
REQ-024 The non-winning channel's rdata SHALL not change.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, busy=0, round-robin pointer to ch0-first.
REQ-026 Reset asserted during ACCESS SHALL abort the access: no write commit, no rvalid.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 First arbitration SHALL occur at the first clock edge with reset_n high.

Structure
REQ-029 Shared package SHALL hold ADDR_W/DATA_W defaults and the FSM state encoding (IDLE=0, ACCESS=1, RESP=2).
REQ-030 Storage SHALL be a sub-module sram_1rw_sync (single port, synchronous write, registered read, no reset); the arbiter instantiates one copy and muxes channel fields into it.
REQ-031 Memory data path SHALL be unidirectional (separate wdata/rdata); no tri-state buses.

Verification
REQ-032 ch0 write addr 0x005 data 0xA5, then ch0 read 0x005 -> gnt0 at N+1, rvalid0 at N+2 with rdata0=0xA5, rvalid1 stays 0.
REQ-033 req0 and req1 both high from reset, continuously held, reads -> grants alternate ch0, ch1, ch0, ch1, spaced 3 cycles.
REQ-034 ch1 write 0x3FF=0x5A same cycle as ch0 read 0x3FF -> ch0 granted first returns old value; next ch1 write; then ch0 read returns 0x5A.
REQ-035 reset_n pulsed low during ACCESS of write 0x010=0xFF (prior value 0x11) -> outputs zero immediately, later read 0x010 returns 0x11.
REQ-036 addr 0x400 with ADDR_W=10 write 0x77, read 0x000 -> rdata=0x77 (wrap).
REQ-037 req1 dropped before gnt while ch0 busy -> no gnt1, no memory change, busy returns 0 after RESP.

Source files
------------

// File: rtl/sram_arb_2ch_pkg.sv
// Shared defaults and FSM encoding for the two-channel SRAM arbiter.
package sram_arb_2ch_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
endpackage

// File: rtl/sram_arb_2ch_sram.sv
// Single-port synchronous SRAM: write on enable+we, registered read on enable+!we.
module sram_1rw_sync #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/sram_arb_2ch.sv
// Two-channel round-robin arbiter in front of one single-port SRAM;
// every access is IDLE -> ACCESS -> RESP, so channels are fully serialized.
module sram_arb_2ch
  import sram_arb_2ch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [1:0]        state_dbg
);
  // Handshake: a requester holds req and its fields stable until its gnt
  // pulse; req is only sampled in IDLE, so a req still high after RESP is a
  // fresh request and a req dropped before gnt is simply never seen.
  logic [1:0]        state;
  logic              win;
  logic              prio1;
  logic              pick;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rd_hold0;
  logic [DATA_W-1:0] rd_hold1;
  logic [DATA_W-1:0] mem_q;

  // prio1 names the channel that wins a tie: the one not granted last.
  assign pick = (req0 && req1) ? prio1 : req1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      win       <= 1'b0;
      prio1     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_hold0  <= '0;
      rd_hold1  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            win       <= pick;
            prio1     <= ~pick;
            lat_we    <= pick ? we1 : we0;
            lat_addr  <= pick ? addr1 : addr0;
            lat_wdata <= pick ? wdata1 : wdata0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: state <= ST_RESP;
        ST_RESP: begin
          if (!lat_we && !win) rd_hold0 <= mem_q;
          if (!lat_we &&  win) rd_hold1 <= mem_q;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The SRAM is enabled only in ACCESS; an async reset leaves ACCESS before
  // the closing edge, which is what aborts an in-flight write.
  sram_1rw_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sram (
    .clk   (clk),
    .en    (state == ST_ACCESS),
    .we    (lat_we),
    .addr  (lat_addr),
    .wdata (lat_wdata),
    .rdata (mem_q)
  );

  assign gnt0      = (state == ST_ACCESS) && !win;
  assign gnt1      = (state == ST_ACCESS) &&  win;
  assign rvalid0   = (state == ST_RESP) && !lat_we && !win;
  assign rvalid1   = (state == ST_RESP) && !lat_we &&  win;
  assign rdata0    = rvalid0 ? mem_q : rd_hold0;
  assign rdata1    = rvalid1 ? mem_q : rd_hold1;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
endmodule

// File: tb/tb_sram_arb_2ch.sv
// Directed bench for sram_arb_2ch with a memory model and a read-data scoreboard.
module tb_sram_arb_2ch;
  import sram_arb_2ch_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;
  logic [1:0]    state_dbg;

  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arb_2ch #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {gnt0, gnt1}, 0);
    chk({tag, "_rvalid"}, {rvalid0, rvalid1}, 0);
    chk({tag, "_rdata"}, {rdata0, rdata1}, 0);
    chk({tag, "_busy"}, busy, 0);
    last_rd0 = '0;
    last_rd1 = '0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge back in IDLE.
  task automatic do_access(input int ch, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    int n;
    logic [DW-1:0] e;
    if (ch == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ch == 0 ? gnt0 : gnt1) && n < 10);
    chk("gnt_latency", n, 1);
    chk("gnt_other", ch == 0 ? gnt1 : gnt0, 0);
    chk("state_access", state_dbg, ST_ACCESS);
    req0 = 1'b0;
    req1 = 1'b0;
    if (we) exp_mem[a] = d;
    else    exp_q.push_back(exp_mem[a]);
    @(negedge clk);
    chk("rvalid_win", ch == 0 ? rvalid0 : rvalid1, !we);
    chk("rvalid_other", ch == 0 ? rvalid1 : rvalid0, 0);
    chk("rdata_other_held", ch == 0 ? rdata1 : rdata0, ch == 0 ? last_rd1 : last_rd0);
    if (!we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rdata", ch == 0 ? rdata0 : rdata1, e);
      if (ch == 0) last_rd0 = e; else last_rd1 = e;
    end
    @(negedge clk);
    chk("busy_after_resp", busy, 0);
  endtask

  initial begin
    logic [10:0] wide_addr;
    logic [DW-1:0] e;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // ch0 write then read, latency and single-channel response
    do_access(0, 1'b1, 10'h005, 8'hA5);
    do_access(0, 1'b0, 10'h005, 8'h00);

    // address wrap: 0x400 folds onto 0x000
    wide_addr = 11'h400;
    do_access(0, 1'b1, wide_addr[AW-1:0], 8'h77);
    do_access(1, 1'b0, 10'h000, 8'h00);

    // simultaneous ch0 read / ch1 write of 0x3FF with ch0 preferred after reset
    do_access(1, 1'b1, 10'h3FF, 8'h12);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rr_reset");
    @(negedge clk);
    reset_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h3FF; wdata1 = 8'h5A;
    @(negedge clk);
    chk("tie_gnt0", gnt0, 1);
    chk("tie_gnt1", gnt1, 0);
    req0 = 1'b0;
    exp_q.push_back(exp_mem[10'h3FF]);
    @(negedge clk);
    chk("tie_rvalid0", rvalid0, 1);
    e = exp_q.pop_front();
    chk("tie_old_data", rdata0, e);
    last_rd0 = e;
    @(negedge clk);
    chk("tie_idle", busy, 0);
    @(negedge clk);
    chk("tie_gnt1_next", gnt1, 1);
    chk("tie_gnt0_next", gnt0, 0);
    req1 = 1'b0;
    exp_mem[10'h3FF] = 8'h5A;
    @(negedge clk);
    chk("tie_write_no_rvalid", {rvalid0, rvalid1}, 0);
    @(negedge clk);
    do_access(0, 1'b0, 10'h3FF, 8'h00);

    // both channels reading continuously from reset: grants alternate every 3 cycles
    do_access(0, 1'b1, 10'h030, 8'h33);
    do_access(1, 1'b1, 10'h031, 8'h44);
    reset_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h030;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h031;
    #1;
    chk_reset_outputs("rr2_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("alt_gnt0", gnt0, (i % 3 == 0) && ((i / 3) % 2 == 0));
      chk("alt_gnt1", gnt1, (i % 3 == 0) && ((i / 3) % 2 == 1));
      chk("alt_busy", busy, (i % 3) != 2);
      if (i % 3 == 0) exp_q.push_back(exp_mem[((i / 3) % 2 == 1) ? 10'h031 : 10'h030]);
      if (i % 3 == 1) begin
        chk("alt_rvalid0", rvalid0, (i / 3) % 2 == 0);
        chk("alt_rvalid1", rvalid1, (i / 3) % 2 == 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("alt_rdata", ((i / 3) % 2 == 1) ? rdata1 : rdata0, e);
          if ((i / 3) % 2 == 1) last_rd1 = e; else last_rd0 = e;
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("alt_done_busy", busy, 0);

    // reset during ACCESS aborts the write
    do_access(0, 1'b1, 10'h010, 8'h11);
    do_access(0, 1'b0, 10'h010, 8'h00);
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h010; wdata0 = 8'hFF;
    @(negedge clk);
    chk("abort_gnt0", gnt0, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    req0 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    do_access(0, 1'b0, 10'h010, 8'h00);

    // ch1 request raised during ch0 access and dropped before any grant
    do_access(0, 1'b1, 10'h040, 8'h66);
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h041;
    @(negedge clk);
    chk("wd_gnt0", gnt0, 1);
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h040; wdata1 = 8'hEE;
    exp_q.push_back(exp_mem[10'h041]);
    @(negedge clk);
    req1 = 1'b0;
    chk("wd_rvalid0", rvalid0, 1);
    e = exp_q.pop_front();
    chk("wd_rdata0", rdata0, e);
    last_rd0 = e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wd_no_gnt1", gnt1, 0);
      chk("wd_busy", busy, 0);
    end
    do_access(1, 1'b0, 10'h040, 8'h00);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) exp_mem[i] = 'x;
  end
endmodule
